dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory. It lets the pipeline MEM-stage port (r0) and a secondary requester such as DMA or debug (r1) share the memory through a req/ack handshake. Grants are round-robin, and each access occupies the memory for a parameterised number of cycles. The block latches each request, drives the memory control and data lines, and returns registered read data.

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported data memory between
// the MEM-stage port (r0) and a secondary requester (r1).
//
// state  | meaning
// IDLE   | no owner, memory lines quiet, arbitrate on any request
// ACCESS | owner's latched access driven to memory for LAT cycles
// RESP   | one-cycle ack to owner, no arbitration (blocks stale regrant)
module dmem_arbiter #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_req_i,
    input  logic              r0_wr_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_ack_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    input  logic              r1_req_i,
    input  logic              r1_wr_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_ack_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              last_p;
    logic              owner;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              sel;
    logic              in_access;

    // On contention the port not granted last wins; last_p resets to 1 so r0 goes first.
    assign sel = (r0_req_i && r1_req_i) ? ~last_p : r1_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            last_p   <= 1'b1;
            owner    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (r0_req_i || r1_req_i) begin
                        owner   <= sel;
                        last_p  <= sel;
                        wr_q    <= sel ? r1_wr_i    : r0_wr_i;
                        addr_q  <= sel ? r1_addr_i  : r0_addr_i;
                        wdata_q <= sel ? r1_wdata_i : r0_wdata_i;
                        cnt     <= 4'(LAT - 1);
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!wr_q) begin
                            if (owner) rdata1_q <= mem_rdata_i;
                            else       rdata0_q <= mem_rdata_i;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_access   = (state == S_ACCESS);
    assign busy_o      = (state != S_IDLE);
    assign grant_o     = busy_o ? {owner, ~owner} : 2'b00;
    assign mem_addr_o  = in_access ? addr_q  : '0;
    assign mem_wdata_o = in_access ? wdata_q : '0;
    assign mem_rd_o    = in_access && !wr_q;
    // Single write strobe in the last occupancy cycle.
    assign mem_wr_o    = in_access && wr_q && (cnt == 4'd0);
    assign r0_ack_o    = (state == S_RESP) && !owner;
    assign r1_ack_o    = (state == S_RESP) && owner;
    assign r0_rdata_o  = rdata0_q;
    assign r1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (LAT=1, LAT=3) behind word-indexed memory
// models, checked cycle by cycle against a transaction-level reference.
module tb_dmem_arbiter;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk_i = 1'b0;
    logic        rst[2];
    logic        req[2][2];
    logic        wr[2][2];
    logic [31:0] addr[2][2];
    logic [31:0] wdata[2][2];
    logic        ack[2][2];
    logic [31:0] rdata[2][2];
    logic [31:0] mem_addr[2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];
    logic        mem_wr[2];
    logic        mem_rd[2];
    logic [1:0]  grant[2];
    logic        busy[2];

    logic [31:0] mem[2][16];
    logic [31:0] ref_mem[2][16];
    logic [31:0] exp_rd[2][2];
    int          prio[2];
    int          wr_cnt1 = 0;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.LAT(LAT0), .ADDR_W(32), .DATA_W(32)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst[0]),
        .r0_req_i(req[0][0]), .r0_wr_i(wr[0][0]), .r0_addr_i(addr[0][0]), .r0_wdata_i(wdata[0][0]),
        .r0_ack_o(ack[0][0]), .r0_rdata_o(rdata[0][0]),
        .r1_req_i(req[0][1]), .r1_wr_i(wr[0][1]), .r1_addr_i(addr[0][1]), .r1_wdata_i(wdata[0][1]),
        .r1_ack_o(ack[0][1]), .r1_rdata_o(rdata[0][1]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_wr_o(mem_wr[0]),
        .mem_rd_o(mem_rd[0]), .mem_rdata_i(mem_rdata[0]), .grant_o(grant[0]), .busy_o(busy[0])
    );

    dmem_arbiter #(.LAT(LAT1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst[1]),
        .r0_req_i(req[1][0]), .r0_wr_i(wr[1][0]), .r0_addr_i(addr[1][0]), .r0_wdata_i(wdata[1][0]),
        .r0_ack_o(ack[1][0]), .r0_rdata_o(rdata[1][0]),
        .r1_req_i(req[1][1]), .r1_wr_i(wr[1][1]), .r1_addr_i(addr[1][1]), .r1_wdata_i(wdata[1][1]),
        .r1_ack_o(ack[1][1]), .r1_rdata_o(rdata[1][1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_wr_o(mem_wr[1]),
        .mem_rd_o(mem_rd[1]), .mem_rdata_i(mem_rdata[1]), .grant_o(grant[1]), .busy_o(busy[1])
    );

    // Memory fixtures: combinational read, write on the clock edge while MemWr is high.
    always @(posedge clk_i) begin
        for (int d = 0; d < 2; d++)
            if (mem_wr[d]) mem[d][mem_addr[d][5:2]] <= mem_wdata[d];
        if (mem_wr[1]) wr_cnt1 <= wr_cnt1 + 1;
    end
    assign mem_rdata[0] = mem[0][mem_addr[0][5:2]];
    assign mem_rdata[1] = mem[1][mem_addr[1][5:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input int d, input logic in_reset);
        check("q_busy", busy[d], 0);
        check("q_grant", grant[d], 0);
        check("q_ack", {ack[d][1], ack[d][0]}, 0);
        check("q_mem_ctl", {mem_wr[d], mem_rd[d]}, 0);
        check("q_mem_addr", mem_addr[d], 0);
        check("q_mem_wdata", mem_wdata[d], 0);
        check("q_rdata0", rdata[d][0], in_reset ? 32'd0 : exp_rd[d][0]);
        check("q_rdata1", rdata[d][1], in_reset ? 32'd0 : exp_rd[d][1]);
    endtask

    task automatic start_req(input int d, input int p, input logic w, input logic [31:0] a,
                             input logic [31:0] wd);
        req[d][p]   = 1'b1;
        wr[d][p]    = w;
        addr[d][p]  = a;
        wdata[d][p] = wd;
    endtask

    // Called in an IDLE cycle with at least one request up; returns in the following IDLE cycle.
    task automatic run_access(input int d, input bit abandon, input bit rereq);
        int          w;
        int          lat;
        logic        a_wr;
        logic [31:0] a_addr;
        logic [31:0] a_wd;
        lat = (d == 0) ? LAT0 : LAT1;
        if (req[d][0] && req[d][1]) w = prio[d];
        else w = req[d][1] ? 1 : 0;
        a_wr   = wr[d][w];
        a_addr = addr[d][w];
        a_wd   = wdata[d][w];
        prio[d] = 1 - w;
        tick();
        for (int c = 1; c <= lat; c++) begin
            check("acc_busy", busy[d], 1);
            check("acc_grant", grant[d], (w == 0) ? 64'd1 : 64'd2);
            check("acc_addr", mem_addr[d], a_addr);
            check("acc_wdata", mem_wdata[d], a_wd);
            check("acc_rd", mem_rd[d], !a_wr);
            check("acc_wr", mem_wr[d], a_wr && (c == lat));
            check("acc_ack", {ack[d][1], ack[d][0]}, 0);
            if (c == 1) begin
                if (abandon) req[d][w] = 1'b0;
                wr[d][w]    = 1'($urandom_range(0, 1));
                addr[d][w]  = $urandom;
                wdata[d][w] = $urandom;
            end
            tick();
        end
        if (a_wr) ref_mem[d][a_addr[5:2]] = a_wd;
        else exp_rd[d][w] = ref_mem[d][a_addr[5:2]];
        check("resp_ack", {ack[d][1], ack[d][0]}, (w == 0) ? 64'd1 : 64'd2);
        check("resp_busy", busy[d], 1);
        check("resp_mem_ctl", {mem_wr[d], mem_rd[d]}, 0);
        check("resp_rdata0", rdata[d][0], exp_rd[d][0]);
        check("resp_rdata1", rdata[d][1], exp_rd[d][1]);
        if (rereq) start_req(d, w, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else req[d][w] = 1'b0;
        tick();
        check_quiet(d, 1'b0);
    endtask

    task automatic reset_pulse(input int d);
        rst[d] = 1'b1;
        req[d][0] = 1'b0;
        req[d][1] = 1'b0;
        #1;
        check_quiet(d, 1'b1);
        tick();
        rst[d] = 1'b0;
        prio[d] = 0;
        exp_rd[d][0] = '0;
        exp_rd[d][1] = '0;
        tick();
        check_quiet(d, 1'b1);
    endtask

    initial begin
        int snap;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            prio[d] = 0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; wr[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
                exp_rd[d][p] = '0;
            end
            for (int i = 0; i < 16; i++) ref_mem[d][i] = '0;
        end
        #2;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        check_quiet(0, 1'b1);
        check_quiet(1, 1'b1);
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        check_quiet(0, 1'b1);
        check_quiet(1, 1'b1);

        // LAT=1: r0 writes 0x4, r1 reads it back
        start_req(0, 0, 1'b1, 32'h4, 32'hDEADBEEF);
        run_access(0, 1'b0, 1'b0);
        start_req(0, 1, 1'b0, 32'h4, 32'h0);
        run_access(0, 1'b0, 1'b0);
        check("lat1_readback", rdata[0][1], 32'hDEADBEEF);

        // Fill every word so later reads have a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) begin
                start_req(d, i % 2, 1'b1, 32'(i * 4), $urandom);
                run_access(d, 1'b0, 1'b0);
            end

        // Contention from reset: both ports re-request at every ack.
        for (int d = 0; d < 2; d++) begin
            reset_pulse(d);
            start_req(d, 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            start_req(d, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            for (int k = 0; k < 4; k++) begin
                check("rr_order", prio[d], k % 2);
                run_access(d, 1'b0, 1'b1);
            end
            while (req[d][0] || req[d][1]) run_access(d, 1'b0, 1'b0);
        end

        // LAT=3 write to 0x8 and readback
        start_req(1, 0, 1'b1, 32'h8, 32'hCAFE0008);
        run_access(1, 1'b0, 1'b0);
        start_req(1, 1, 1'b0, 32'h8, 32'h0);
        run_access(1, 1'b0, 1'b0);
        check("lat3_readback", rdata[1][1], 32'hCAFE0008);

        // Abandoned r1 read: completes once, never regranted.
        start_req(1, 1, 1'b0, 32'h8, 32'h0);
        run_access(1, 1'b1, 1'b0);
        tick();
        check_quiet(1, 1'b0);

        // Reset in the 2nd ACCESS cycle of a LAT=3 write.
        snap = wr_cnt1;
        start_req(1, 0, 1'b1, 32'h0, 32'h12345678);
        tick();
        tick();
        reset_pulse(1);
        check("rmw_no_wr", 64'(wr_cnt1 - snap), 0);
        start_req(1, 1, 1'b0, 32'h0, 32'h0);
        run_access(1, 1'b0, 1'b0);
        check("rmw_old_value", rdata[1][1], ref_mem[1][0]);

        // Random traffic with occasional mid-stream resets.
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 120; r++) begin
                for (int p = 0; p < 2; p++)
                    if (!req[d][p] && $urandom_range(0, 1) == 1)
                        start_req(d, p, 1'($urandom_range(0, 1)), $urandom, $urandom);
                if (!req[d][0] && !req[d][1]) begin
                    tick();
                    check_quiet(d, 1'b0);
                end else if ($urandom_range(0, 15) == 0) begin
                    repeat ($urandom_range(0, (d == 0) ? LAT0 : LAT1)) tick();
                    reset_pulse(d);
                end else begin
                    run_access(d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
                end
            end
            while (req[d][0] || req[d][1]) run_access(d, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
